// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: fetch-side bus; icache PC/hit, predecode and predictor flags, redirect, and the packet to the instruction buffer
interface fetch_ctrl_if;
  logic [63:0] fetch_pc;
  logic icache_valid;
  logic [1:0] branch;
  logic [1:0] halt;
  logic [1:0] bp_taken;
  logic [63:0] bp_target0;
  logic [63:0] bp_target1;
  logic rob_redirect;
  logic [63:0] redirect_pc;
  logic ibuf_ready;
  logic [1:0] out_valid;
  logic [63:0] out_pc0;
  logic [63:0] out_pc1;
  logic [1:0] out_pred_taken;
  logic halted;
  logic [31:0] inst_count;
  modport master(
    output fetch_pc, out_valid, out_pc0, out_pc1, out_pred_taken, halted, inst_count,
    input icache_valid, branch, halt, bp_taken, bp_target0, bp_target1, rob_redirect, redirect_pc, ibuf_ready
  );
  modport slave(
    input fetch_pc, out_valid, out_pc0, out_pc1, out_pred_taken, halted, inst_count,
    output icache_valid, branch, halt, bp_taken, bp_target0, bp_target1, rob_redirect, redirect_pc, ibuf_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: two-wide fetch sequencer; owns fetch_pc, forms 0-2 instruction packets, handles halt and redirect (ports: clock, reset, bus)
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic clock,
  input logic reset,
  fetch_ctrl_if.master bus
);
  typedef enum logic {FETCH, HALTED} state_t;
  state_t state;
  logic [63:0] pc;
  logic [31:0] count;
  logic live, v0, v1, t0, t1, hit_halt, accept;
  logic [63:0] next_pc;
  always_comb begin
    t0 = bus.branch[0] & bus.bp_taken[0];
    t1 = bus.branch[1] & bus.bp_taken[1];
    live = (state == FETCH) & bus.icache_valid & ~bus.rob_redirect & ~reset;
    v0 = live;
    v1 = live & ~pc[2] & ~bus.halt[0] & ~t0;
    hit_halt = (v0 & bus.halt[0]) | (v1 & bus.halt[1]);
    accept = v0 & bus.ibuf_ready;
    // a halting packet parks fetch_pc on the halt instruction itself
    next_pc = bus.halt[0] ? pc :
              (v1 & bus.halt[1]) ? pc + 64'd4 :
              t0 ? bus.bp_target0 :
              (v1 & t1) ? bus.bp_target1 :
              pc + (v1 ? 64'd8 : 64'd4);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      count <= '0;
    end else if (bus.rob_redirect) begin
      state <= FETCH;
      pc <= {bus.redirect_pc[63:2], 2'b00};
    end else if (accept) begin
      state <= hit_halt ? HALTED : FETCH;
      pc <= {next_pc[63:2], 2'b00};
      count <= count + (v1 ? 32'd2 : 32'd1);
    end
  end
  assign bus.fetch_pc = pc;
  assign bus.out_valid = {v1, v0};
  assign bus.out_pc0 = pc;
  assign bus.out_pc1 = pc + 64'd4;
  assign bus.out_pred_taken = {v1 & t1, v0 & t0};
  assign bus.halted = state == HALTED;
  assign bus.inst_count = count;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;
  logic clock = 0;
  logic reset;
  int checks = 0;
  int failures = 0;
  fetch_ctrl_if bus();
  fetch_ctrl dut (.clock(clock), .reset(reset), .bus(bus.master));
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.icache_valid = 1; bus.branch = 0; bus.halt = 0; bus.bp_taken = 0;
    bus.bp_target0 = 0; bus.bp_target1 = 0; bus.rob_redirect = 0;
    bus.redirect_pc = 0; bus.ibuf_ready = 1;
  endtask

  task automatic exp_pc(input string name, input logic [63:0] e);
    checks++;
    if (bus.fetch_pc !== e) begin
      failures++;
      $display("FAIL %s fetch_pc got=%h exp=%h", name, bus.fetch_pc, e);
    end
  endtask

  task automatic exp_valid(input string name, input logic [1:0] e);
    checks++;
    if (bus.out_valid !== e) begin
      failures++;
      $display("FAIL %s out_valid got=%b exp=%b", name, bus.out_valid, e);
    end
  endtask

  task automatic exp_count(input string name, input logic [31:0] e);
    checks++;
    if (bus.inst_count !== e) begin
      failures++;
      $display("FAIL %s inst_count got=%0d exp=%0d", name, bus.inst_count, e);
    end
  endtask

  task automatic exp_halted(input string name, input logic e);
    checks++;
    if (bus.halted !== e) begin
      failures++;
      $display("FAIL %s halted got=%b exp=%b", name, bus.halted, e);
    end
  endtask

  task automatic redirect_to(input logic [63:0] a);
    bus.rob_redirect = 1; bus.redirect_pc = a;
    tick();
    bus.rob_redirect = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    #1;
    exp_valid("reset_cycle", 2'b00);
    tick(); tick();
    reset = 0;
    #1;
    exp_pc("reset_pc", 64'h0);
    exp_count("reset_count", 0);
    exp_halted("reset_halted", 0);
  endtask

  task automatic test_straight();
    for (int i = 0; i < 4; i++) begin
      exp_pc("straight_pc", 64'(8 * i));
      exp_valid("straight_valid", 2'b11);
      tick();
    end
    exp_count("straight_count", 8);
  endtask

  task automatic test_misaligned_taken();
    bus.rob_redirect = 1; bus.redirect_pc = 64'h104;
    #1;
    exp_valid("redir_same_cycle", 2'b00);
    tick();
    bus.rob_redirect = 0;
    #1;
    exp_pc("misal_pc", 64'h104);
    exp_valid("misal_valid", 2'b01);
    exp_count("redir_not_counted", 8);
    tick();
    exp_pc("misal_next", 64'h108);
    exp_count("misal_count", 9);
    redirect_to(64'h200);
    bus.branch = 2'b01; bus.bp_taken = 2'b01; bus.bp_target0 = 64'h200;
    #1;
    exp_valid("taken0_valid", 2'b01);
    checks++;
    if (bus.out_pred_taken !== 2'b01) begin
      failures++;
      $display("FAIL taken0_pred got=%b exp=01", bus.out_pred_taken);
    end
    tick();
    exp_pc("taken0_next", 64'h200);
    exp_count("taken0_count", 10);
  endtask

  task automatic test_slot1_taken();
    idle_inputs();
    redirect_to(64'h40);
    bus.branch = 2'b10; bus.bp_taken = 2'b10; bus.bp_target1 = 64'h80;
    #1;
    exp_valid("taken1_valid", 2'b11);
    checks++;
    if (bus.out_pred_taken !== 2'b10) begin
      failures++;
      $display("FAIL taken1_pred got=%b exp=10", bus.out_pred_taken);
    end
    checks++;
    if (bus.out_pc1 !== 64'h44) begin
      failures++;
      $display("FAIL taken1_pc1 got=%h exp=44", bus.out_pc1);
    end
    tick();
    exp_pc("taken1_next", 64'h80);
    exp_count("taken1_count", 12);
    bus.branch = 2'b00; bus.bp_taken = 2'b11;
    #1;
    exp_valid("nobranch_valid", 2'b11);
    checks++;
    if (bus.out_pred_taken !== 2'b00) begin
      failures++;
      $display("FAIL nobranch_pred got=%b exp=00", bus.out_pred_taken);
    end
    tick();
    exp_pc("nobranch_next", 64'h88);
    exp_count("nobranch_count", 14);
  endtask

  task automatic test_backpressure();
    idle_inputs();
    bus.ibuf_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      exp_valid("bp_valid", 2'b11);
      tick();
      exp_pc("bp_pc", 64'h88);
      exp_count("bp_count", 14);
    end
    bus.ibuf_ready = 1; bus.icache_valid = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      exp_valid("miss_valid", 2'b00);
      tick();
      exp_pc("miss_pc", 64'h88);
      exp_count("miss_count", 14);
    end
    bus.icache_valid = 1;
    #1;
    exp_valid("recover_valid", 2'b11);
    tick();
    exp_pc("recover_pc", 64'h90);
    exp_count("recover_count", 16);
  endtask

  task automatic test_halt();
    idle_inputs();
    redirect_to(64'h30);
    bus.halt = 2'b01;
    #1;
    exp_valid("halt0_valid", 2'b01);
    tick();
    bus.halt = 2'b00;
    #1;
    exp_halted("halt0_halted", 1);
    exp_pc("halt0_pc", 64'h30);
    exp_count("halt0_count", 17);
    for (int i = 0; i < 3; i++) begin
      exp_valid("halted_valid", 2'b00);
      tick();
    end
    exp_pc("halted_pc", 64'h30);
    exp_count("halted_count", 17);
    redirect_to(64'h10);
    #1;
    exp_halted("unhalt", 0);
    exp_pc("unhalt_pc", 64'h10);
    bus.halt = 2'b10;
    #1;
    exp_valid("halt1_valid", 2'b11);
    tick();
    bus.halt = 2'b00;
    exp_halted("halt1_halted", 1);
    exp_pc("halt1_pc", 64'h14);
    exp_count("halt1_count", 19);
    bus.ibuf_ready = 0; bus.icache_valid = 0;
    redirect_to(64'h20);
    exp_halted("redir_stalled_halted", 0);
    exp_pc("redir_stalled_pc", 64'h20);
    bus.ibuf_ready = 1; bus.icache_valid = 1;
  endtask

  task automatic test_priority();
    bus.rob_redirect = 1; bus.redirect_pc = 64'h300;
    #1;
    exp_valid("prio_valid", 2'b00);
    tick();
    exp_pc("prio_pc", 64'h300);
    exp_count("prio_count", 19);
    reset = 1; bus.redirect_pc = 64'h500;
    #1;
    exp_valid("prio_reset_valid", 2'b00);
    tick();
    reset = 0; bus.rob_redirect = 0;
    #1;
    exp_pc("prio_reset_pc", 64'h0);
    exp_count("prio_reset_count", 0);
    exp_halted("prio_reset_halted", 0);
  endtask

  initial begin
    #2;
    test_reset();
    test_straight();
    test_misaligned_taken();
    test_slot1_taken();
    test_backpressure();
    test_halt();
    test_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Two-wide fetch sequencer for the R10K 2-way front end. It owns the fetch PC and presents it to the instruction cache. It qualifies the two returned instruction slots using the per-slot predecode flags (branch, halt) from the fetch decoders plus the branch predictor. It hands a 0–2 instruction packet to the instruction buffer under a ready/valid handshake and applies back-end redirects.

## Interface
- RESET_PC, 64'h0, fetch PC loaded on reset
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- fetch_pc  out  64  address sent to icache; bits [2:0] always 0 or 4
- icache_valid  in  1  icache data for fetch_pc is valid this cycle (hit)
- branch  in  2  predecode branch flag per slot (slot0 = fetch_pc, slot1 = fetch_pc+4)
- halt  in  2  predecode halt flag per slot
- bp_taken  in  2  predictor taken per slot; ignored where branch[i]=0
- bp_target0, bp_target1  in  64 each  predicted target per slot
- rob_redirect  in  1  back end squash/redirect
- redirect_pc  in  64  target of redirect
- ibuf_ready  in  1  instruction buffer can accept 2 instructions this cycle
- out_valid  out  2  per-slot valid of delivered packet
- out_pc0, out_pc1  out  64 each  PCs of slots (fetch_pc, fetch_pc+4)
- out_pred_taken  out  2  bp_taken & branch & out_valid, forwarded to decode
- halted  out  1  fetch stopped on halt, waiting for redirect
- inst_count  out  32  count of instructions accepted by the buffer, wraps at 2^32

## Operation
- States: FETCH, HALTED. Reset → FETCH, fetch_pc=RESET_PC, inst_count=0.
- Slot1 is eligible only when fetch_pc[2]==0, because the icache line is 8 bytes. With fetch_pc[2]==1, only slot0 can be valid.
- Packet formation in FETCH with icache_valid=1 and rob_redirect=0:
  - v0 = 1.
  - v1 = eligible1 & ~halt[0] & ~(branch[0]&bp_taken[0]).
  - out_valid = {v1,v0}.
- Next PC:
  - If slot0 is predicted taken, next = bp_target0.
  - Else if v1 and slot1 is predicted taken, next = bp_target1.
  - Else next = fetch_pc + 4·popcount(out_valid).
  - Addition is 64-bit and wraps.
- Halt: halt on any valid slot suppresses later slots and does not advance the PC. On acceptance, state → HALTED and fetch_pc holds the halt PC. The halt instruction itself is delivered.
- HALTED: out_valid=0, halted=1. Only rob_redirect leaves HALTED, because an older mispredict can squash the halt.
- Acceptance: the packet is accepted when |out_valid & ibuf_ready. Then fetch_pc ← next and inst_count += popcount(out_valid).
  - With ibuf_ready=0, everything holds. out_valid remains asserted and stable while fetch_pc and inputs are stable.
- icache miss (icache_valid=0): out_valid=0, fetch_pc holds.
- Priority, highest first: reset > rob_redirect > halt/accept > hold.
  - rob_redirect forces out_valid=0 in the same cycle and inst_count does not increment.
  - Next cycle: fetch_pc=redirect_pc, state=FETCH.

## Timing
- fetch_pc, state and inst_count are registers. out_valid, out_pc*, out_pred_taken and halted are combinational from state, fetch_pc and the current inputs.
- Icache is assumed combinational-hit, so a hit yields a packet in the same cycle fetch_pc is presented. Throughput is up to 2 instructions per cycle.
- Redirect-to-first-packet latency is 1 cycle.
- During the reset cycle, out_valid=0 regardless of inputs. After reset: fetch_pc=RESET_PC, halted=0, inst_count=0, out_valid depends on icache_valid.
- Reset mid-operation (including in HALTED) discards all state with no delivery.
- rob_redirect while ibuf_ready=0 or icache_valid=0 still redirects. rob_redirect in HALTED clears halted next cycle.
- Predicted target with bits [1:0]≠0 is illegal input; fetch_pc[1:0] is forced to 0.

## Test plan
- Straight-line: reset, icache_valid=1, ibuf_ready=1, no flags → out_valid=11 each cycle, fetch_pc 0,8,16,24; inst_count=8 after 4 cycles.
- Misaligned + taken: redirect_pc=0x104 → next cycle out_valid=01. Then branch=01, bp_taken=01, bp_target0=0x200 at pc 0x200 yields out_valid=01 and next fetch_pc=0x200.
- Slot1 taken: pc=0x40, branch=10, bp_taken=10, bp_target1=0x80 → out_valid=11, out_pred_taken=10, next fetch_pc=0x80.
- Backpressure/miss: ibuf_ready=0 for 3 cycles, then icache_valid=0 for 2 cycles → fetch_pc and inst_count unchanged, out_valid stable then 00; resumes on recovery.
- Halt: halt=01 at pc 0x30 → out_valid=01, accepted; then halted=1, out_valid=00 indefinitely. rob_redirect to 0x10 → next cycle FETCH at 0x10, halted=0.
- Redirect priority: rob_redirect concurrent with a valid accepted packet and with reset → packet not counted; reset wins and fetch_pc=RESET_PC.
